// File: rtl/sky_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : sky_rom_loader
// Description : Download ingest stage for the Sky Skipper core. Forwards ROM
//               bytes (index 0) to the core load port with a registered
//               one-cycle strobe and captures DIP bytes (index 254) into an
//               8-entry register file. Holds the core in reset during a load
//               and for POST_CYCLES afterwards, then reports completeness.
//               Optional build macro SKY_LOADER_CHECKSUM_EN enables a 16-bit
//               wrap-around checksum of accepted ROM bytes; without it the
//               checksum output is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sky_rom_loader #(
  parameter int ROM_BYTES   = 98304,
  parameter int POST_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic [7:0]  sw0,
  output logic [7:0]  sw1,
  output logic [7:0]  sw2,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_POST = 2'd2
  } state_t;

  localparam logic [16:0] c_rom_len   = 17'(ROM_BYTES);
  localparam logic [24:0] c_rom_limit = 25'(ROM_BYTES);
  localparam logic [7:0]  c_post_len  = 8'(POST_CYCLES);
  localparam logic [16:0] c_cnt_max   = '1;

  state_t      state_q, state_d;
  logic [16:0] dl_addr_q;
  logic [7:0]  dl_data_q;
  logic        dl_wr_q;
  logic [16:0] cnt_q;
  logic        ovf_q;
  logic        done_q;
  logic        err_q;
  logic [7:0]  post_cnt_q;
  logic [7:0]  dip_q [8];

  logic w_rom_byte;
  logic w_dip_byte;
  logic w_start;
  logic w_accept;
  logic w_overrun;
  logic w_enter;
  logic w_exit;

  assign w_rom_byte = ioctl_download & ioctl_wr & (ioctl_index == 8'd0);
  assign w_dip_byte = ioctl_download & ioctl_wr & (ioctl_index == 8'd254)
                    & (ioctl_addr[24:3] == 22'd0);
  assign w_start    = ioctl_download & (ioctl_index == 8'd0);
  assign w_accept   = w_rom_byte & (state_q == S_LOAD) & (ioctl_addr < c_rom_limit);
  assign w_overrun  = w_rom_byte & (state_q == S_LOAD) & (ioctl_addr >= c_rom_limit);

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus one-cycle LOAD entry/exit qualifiers for the datapath.
  always_comb begin
    state_d = state_q;
    w_enter = 1'b0;
    w_exit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d = S_LOAD;
          w_enter = 1'b1;
        end
      end
      S_LOAD: begin
        if (!ioctl_download) begin
          state_d = S_POST;
          w_exit  = 1'b1;
        end
      end
      S_POST: begin
        // Download can only be high here if it rose again, so restart at once.
        if (w_start) begin
          state_d = S_LOAD;
          w_enter = 1'b1;
        end else if (post_cnt_q <= 8'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load port, byte counter, overflow tracking, status flags and post-load timer.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
      dl_wr_q    <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      post_cnt_q <= '0;
    end else begin
      dl_wr_q <= w_accept;
      if (w_accept) begin
        dl_addr_q <= ioctl_addr[16:0];
        dl_data_q <= ioctl_dout;
      end
      if (w_enter) begin
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (w_accept && (cnt_q != c_cnt_max)) cnt_q <= cnt_q + 17'd1;
        if (w_overrun) ovf_q <= 1'b1;
      end
      if (w_exit) begin
        done_q <= (cnt_q == c_rom_len) && !ovf_q;
        err_q  <= !((cnt_q == c_rom_len) && !ovf_q);
      end
      if (w_exit) post_cnt_q <= c_post_len;
      else if ((state_q == S_POST) && (post_cnt_q != 8'd0)) post_cnt_q <= post_cnt_q - 8'd1;
    end
  end

  // DIP register file, written from any state.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) dip_q[i] <= '0;
    end else if (w_dip_byte) begin
      dip_q[ioctl_addr[2:0]] <= ioctl_dout;
    end
  end

`ifdef SKY_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Sum accepted bytes alongside their dl_wr pulse; only moves while loading.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)         checksum_q <= '0;
    else if (w_enter)  checksum_q <= '0;
    else if (w_accept) checksum_q <= checksum_q + {8'd0, ioctl_dout};
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'd0;
`endif

  // Entries 3..7 exist for the HPS but are not routed to the core.
  logic w_dip_unused;
  assign w_dip_unused = ^{dip_q[3], dip_q[4], dip_q[5], dip_q[6], dip_q[7]};

  assign dl_addr    = dl_addr_q;
  assign dl_data    = dl_data_q;
  assign dl_wr      = dl_wr_q;
  assign sw0        = dip_q[0];
  assign sw1        = dip_q[1];
  assign sw2        = dip_q[2];
  assign load_done  = done_q;
  assign load_err   = err_q;
  // Combinational so the core sees reset without waiting for a clock.
  assign core_reset = reset | (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sky_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sky_rom_loader
// Description : Self-checking bench for sky_rom_loader (ROM_BYTES=16 override).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sky_rom_loader;

  localparam int ROM_BYTES   = 16;
  localparam int POST_CYCLES = 5;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic [7:0]  sw0, sw1, sw2;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [15:0] checksum;

  sky_rom_loader #(.ROM_BYTES(ROM_BYTES), .POST_CYCLES(POST_CYCLES)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr),
    .sw0(sw0), .sw1(sw1), .sw2(sw2),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err),
    .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int nvec   = 0;
  int nmis   = 0;
  int npulse = 0;
  bit chk_en = 0;

  // Behavioural model: what the outputs must be after each clock edge.
  bit         m_loading;
  int         m_post_left;
  int         m_count;
  bit         m_ovf;
  bit         m_done, m_err;
  int         m_sum;
  bit         m_wr;
  int         m_addr;
  logic [7:0] m_data;
  logic [7:0] m_dip [8];

  function automatic void model_reset();
    m_loading = 0; m_post_left = 0; m_count = 0; m_ovf = 0;
    m_done = 0; m_err = 0; m_sum = 0; m_wr = 0; m_addr = 0; m_data = 8'h00;
    for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;
  endfunction

  function automatic void model_step(bit dl, logic [7:0] idx, bit wr, int addr, logic [7:0] dout);
    m_wr = 0;
    if (dl && wr && idx == 8'd254 && addr < 8) m_dip[addr] = dout;
    if (m_loading) begin
      if (!dl) begin
        m_loading   = 0;
        m_done      = (m_count == ROM_BYTES) && !m_ovf;
        m_err       = !m_done;
        m_post_left = POST_CYCLES;
      end else if (wr && idx == 8'd0) begin
        if (addr < ROM_BYTES) begin
          m_wr = 1; m_addr = addr; m_data = dout; m_count++;
          m_sum = (m_sum + int'(dout)) & 16'hFFFF;
        end else begin
          m_ovf = 1;
        end
      end
    end else if (dl && idx == 8'd0) begin
      m_loading = 1; m_post_left = 0; m_count = 0; m_ovf = 0;
      m_done = 0; m_err = 0; m_sum = 0;
    end else if (m_post_left > 0) begin
      m_post_left--;
    end
  endfunction

  function automatic logic [15:0] exp_checksum();
`ifdef SKY_LOADER_CHECKSUM_EN
    return 16'(m_sum);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every cycle against the model, away from the active edge.
  always @(negedge clk_sys) begin
    if (dl_wr === 1'b1) npulse++;
    if (chk_en) begin
      check("dl_wr",      {31'd0, dl_wr},      {31'd0, m_wr});
      check("dl_addr",    {15'd0, dl_addr},    32'(m_addr));
      check("dl_data",    {24'd0, dl_data},    {24'd0, m_data});
      check("sw0",        {24'd0, sw0},        {24'd0, m_dip[0]});
      check("sw1",        {24'd0, sw1},        {24'd0, m_dip[1]});
      check("sw2",        {24'd0, sw2},        {24'd0, m_dip[2]});
      check("core_reset", {31'd0, core_reset},
            {31'd0, (reset | m_loading | (m_post_left > 0))});
      check("load_done",  {31'd0, load_done},  {31'd0, m_done});
      check("load_err",   {31'd0, load_err},   {31'd0, m_err});
      check("checksum",   {16'd0, checksum},   {16'd0, exp_checksum()});
    end
  end

  task automatic cyc(input bit dl, input logic [7:0] idx, input bit wr, input int addr, input logic [7:0] dout);
    ioctl_download = dl;
    ioctl_index    = idx;
    ioctl_wr       = wr;
    ioctl_addr     = 25'(addr);
    ioctl_dout     = dout;
    @(posedge clk_sys);
    model_step(dl, idx, wr, addr, dout);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (core_reset === 1'b1 && n < 64) begin
      cyc(0, 8'd0, 0, 0, 8'h00);
      n++;
    end
    check("idle_reached", {31'd0, core_reset}, 32'd0);
  endtask

  task automatic async_reset(input int hold);
    #2;
    reset = 1'b1;
    model_reset();
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = 8'h00;
    repeat (hold) @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    bit gap;

    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'h00;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_dl_addr",    {15'd0, dl_addr},    32'd0);
    check("rst_dl_wr",      {31'd0, dl_wr},      32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_load_done",  {31'd0, load_done},  32'd0);
    check("rst_sw0",        {24'd0, sw0},        32'd0);
    reset = 1'b0;
    #1;
    check("idle_core_reset", {31'd0, core_reset}, 32'd0);
    chk_en = 1;

    // Full load, data 0x01..0x10.
    p0 = npulse;
    cyc(1, 8'd0, 0, 0, 8'h00);
    for (int i = 0; i < ROM_BYTES; i++) cyc(1, 8'd0, 1, i, 8'(i + 1));
    cyc(0, 8'd0, 0, 0, 8'h00);
    check("full_pulses", 32'(npulse - p0), 32'd16);
    check("full_done",   {31'd0, load_done}, 32'd1);
    check("full_err",    {31'd0, load_err},  32'd0);
`ifdef SKY_LOADER_CHECKSUM_EN
    check("full_checksum", {16'd0, checksum}, 32'h0088);
`else
    check("full_checksum", {16'd0, checksum}, 32'h0000);
`endif
    n = 1;
    while (core_reset === 1'b1 && n < 64) begin
      cyc(0, 8'd0, 0, 0, 8'h00);
      n++;
    end
    check("post_len", 32'(n), 32'(POST_CYCLES + 1));

    // Short load: 10 of 16 bytes.
    cyc(1, 8'd0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1, 8'd0, 1, i, 8'(8'h30 + i));
    cyc(0, 8'd0, 0, 0, 8'h00);
    check("short_err",  {31'd0, load_err},  32'd1);
    check("short_done", {31'd0, load_done}, 32'd0);
    wait_idle();

    // Overflow: 16 good bytes plus address 16.
    p0 = npulse;
    cyc(1, 8'd0, 0, 0, 8'h00);
    for (int i = 0; i < ROM_BYTES; i++) cyc(1, 8'd0, 1, i, 8'(8'h50 + i));
    cyc(1, 8'd0, 1, 16, 8'hAA);
    cyc(0, 8'd0, 1, 3, 8'h77);   // strobe on the falling edge is ignored
    check("ovf_pulses", 32'(npulse - p0), 32'd16);
    check("ovf_err",    {31'd0, load_err}, 32'd1);
    wait_idle();

    // DIP capture.
    cyc(1, 8'd254, 0, 0, 8'h00);
    cyc(1, 8'd254, 1, 0, 8'h0F);
    cyc(1, 8'd254, 1, 1, 8'hC2);
    cyc(1, 8'd254, 1, 2, 8'h01);
    cyc(1, 8'd254, 1, 8, 8'hFF);
    cyc(0, 8'd0, 0, 0, 8'h00);
    check("dip_sw0",  {24'd0, sw0}, 32'h0F);
    check("dip_sw1",  {24'd0, sw1}, 32'hC2);
    check("dip_sw2",  {24'd0, sw2}, 32'h01);
    check("dip_core_reset", {31'd0, core_reset}, 32'd0);

    // Async reset after byte 5 with byte 6 already strobing.
    cyc(1, 8'd0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1, 8'd0, 1, i, 8'(8'h21 + i));
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h26;
    p0 = npulse;
    async_reset(2);
    for (int i = 0; i < 3; i++) cyc(0, 8'd0, 0, 0, 8'h00);
    check("rst_no_pulse",  32'(npulse - p0), 32'd0);
    check("rst_abort_done", {31'd0, load_done}, 32'd0);
    check("rst_abort_cr",   {31'd0, core_reset}, 32'd0);

    // Clean restart after the abort, data 0xF0.., then re-download during POST.
    cyc(1, 8'd0, 0, 0, 8'h00);
    for (int i = 0; i < ROM_BYTES; i++) cyc(1, 8'd0, 1, i, 8'(8'hF0 + i));
    cyc(0, 8'd0, 0, 0, 8'h00);
    check("restart_done", {31'd0, load_done}, 32'd1);
    gap = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 8'd0, 0, 0, 8'h00);
      if (core_reset !== 1'b1) gap = 1;
    end
    cyc(1, 8'd0, 0, 0, 8'h00);
    if (core_reset !== 1'b1) gap = 1;
    check("redl_done_cleared", {31'd0, load_done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'd0, 1, i, 8'(8'h40 + i));
      if (core_reset !== 1'b1) gap = 1;
    end
    cyc(0, 8'd0, 0, 0, 8'h00);
    if (core_reset !== 1'b1) gap = 1;
    check("redl_no_gap", {31'd0, gap}, 32'd0);
    check("redl_err",    {31'd0, load_err}, 32'd1);
    wait_idle();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sky_rom_loader.md
# sky_rom_loader

Ingest stage between the HPS download channel and the Sky Skipper core. Qualifies the `ioctl_*` byte stream, forwards ROM bytes (index 0) to the core's `dl_*` load port with a registered one-cycle write strobe, and captures DIP bytes (index 254) into holding registers. Sequences the core reset around a load: held during the transfer, then for a fixed post-load window. Reports load completeness.

## Interface
Parameters:
- `ROM_BYTES`, 98304: expected ROM image length; accepted addresses are 0..ROM_BYTES-1.
- `POST_CYCLES`, 16: cycles `core_reset` stays high after download ends (1..255).

Ports:
- `clk_sys`  in  1  system clock; sole clock of the block.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_download`  in  1  HPS download active.
- `ioctl_index`  in  8  download target: 0 = ROM, 254 = DIP.
- `ioctl_wr`  in  1  byte-valid strobe, single cycle.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `dl_addr`  out  17  ROM write address to core.
- `dl_data`  out  8  ROM write data to core.
- `dl_wr`  out  1  ROM write strobe to core.
- `sw0`, `sw1`, `sw2`  out  8 each  DIP bytes 0..2.
- `core_reset`  out  1  reset request to core.
- `load_done`  out  1  last load was complete and error-free.
- `load_err`  out  1  last load was short or overflowed.
- `checksum`  out  16  running sum of accepted ROM bytes.

## Operation
- Qualified ROM byte: `ioctl_download & ioctl_wr & ioctl_index==0`. Qualified DIP byte: same with index 254 and `ioctl_addr[24:3]==0`.
- FSM states: IDLE, LOAD, POST.
  - IDLE -> LOAD on `ioctl_download & ioctl_index==0`. On entry: clear byte counter, `checksum`, `load_done`, `load_err`, and overflow flag.
  - LOAD -> POST when `ioctl_download` falls. On that cycle: `load_done` <= (count==ROM_BYTES & !overflow); `load_err` <= its complement.
  - POST: decrementing counter loaded with POST_CYCLES; POST -> IDLE when counter reaches 0. Rising download with index 0 during POST -> LOAD, re-entering with all clears.
- `core_reset` = `reset` | (state != IDLE). Combinational OR so that reset propagates immediately.
- ROM bytes in LOAD with addr < ROM_BYTES: register `dl_addr`=addr[16:0], `dl_data`, pulse `dl_wr`; count += 1 (17-bit, saturates at 2^17-1). Addr >= ROM_BYTES: no `dl_wr`, no count; set overflow.
- DIP bytes: write an 8-entry register file at addr[2:0] in any state; entries 0..2 drive `sw0..sw2`. DIP downloads never change FSM state or `core_reset`.
- Writes with `ioctl_download` low are ignored, including a write strobe coincident with the falling edge.

## Timing
- Reset values: state IDLE, `dl_addr`=0, `dl_data`=0, `dl_wr`=0, DIP file all 0x00, `load_done`=0, `load_err`=0, `checksum`=0, count 0. `core_reset` follows `reset` combinationally.
- ROM byte latency: `dl_*` valid exactly 1 cycle after the qualifying `ioctl_wr`. `dl_wr` is high for 1 cycle per accepted byte. Back-to-back strobes yield back-to-back pulses.
- DIP register updates 1 cycle after the strobe.
- `load_done`/`load_err` update 1 cycle after the falling edge of `ioctl_download`.
- `core_reset` falls POST_CYCLES+1 cycles after that falling edge.
- Async `reset` mid-load aborts to IDLE. No further `dl_wr` is issued, including one already pipelined for the next cycle.

## Configuration
- `SKY_LOADER_CHECKSUM_EN` defined: `checksum` is a 16-bit wrap-around sum of `dl_data` over every accepted ROM byte, updated with `dl_wr`, frozen from LOAD exit until next LOAD entry.
- Not defined: `checksum` tied to 0. No adder is synthesized.

## Test plan
- Full load, ROM_BYTES=16 bench override: 16 strobes, data 0x01..0x10, then download low -> 16 `dl_wr` pulses 1 cycle delayed with matching addr/data. `load_done`=1, `load_err`=0, `checksum`=0x0088 (macro on) / 0 (off). `core_reset` low POST_CYCLES+1 cycles after end.
- Short load: 10 of 16 bytes -> `load_err`=1, `load_done`=0.
- Overflow: 16 valid bytes plus addr 16 -> no 17th `dl_wr`, `load_err`=1.
- DIP capture: index 254, addr 0/1/2 data 0x0F/0xC2/0x01, then addr 8 data 0xFF -> `sw0`=0x0F, `sw1`=0xC2, `sw2`=0x01. Addr 8 is ignored. `core_reset` stays low throughout.
- Async reset asserted after byte 5 of a load -> `dl_wr` never pulses again, state IDLE, `load_done`=0. The next download restarts cleanly from count 0.
- Re-download during POST -> immediate LOAD, counters cleared, `core_reset` held continuously with no low gap.
